md6_s_step_sequencer: RTL and testbench

//  Downstream consumer of the S round-constant table (R_MAX x C words of W bits, flat bus).
//  On start, streams one S word per accepted step, in round-major order, to the compression

---
 rtl/md6_pkg.sv | 27 ++
 rtl/md6_s_step_sequencer_if.sv | 25 ++
 rtl/md6_word_select.sv | 18 +
 rtl/md6_s_step_sequencer.sv | 124 ++++++++++++
 tb/tb_md6_s_step_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/md6_pkg.sv
// Shared MD6 constants, FSM state type and clog2 helper
// for the S-constant step sequencer and its word mux.
package md6_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int W     = 64;
  localparam int C     = 16;
  localparam int R_MAX = 11;
  localparam int RW    = 4;
  localparam int SW    = clog2(C);
  localparam int NW    = R_MAX * C;
  localparam int KW    = clog2(NW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/md6_s_step_sequencer_if.sv
// S-word stream to the compression step engine.
// master drives word/valid/indices/last; slave drives ready.
interface md6_s_step_sequencer_if;
  import md6_pkg::*;

  logic [W-1:0]  s_word;
  logic          s_valid;
  logic          s_ready;
  logic [RW-1:0] round_idx;
  logic [SW-1:0] step_idx;
  logic          last_step;

  modport master (
    output s_word, s_valid, round_idx,
    output step_idx, last_step,
    input  s_ready
  );

  modport slave (
    input  s_word, s_valid, round_idx,
    input  step_idx, last_step,
    output s_ready
  );

endinterface

// File: rtl/md6_word_select.sv
// Combinational NW:1 W-bit mux over the flat S table.
// i_table: flat table, i_k: word offset, o_word: selected word.
module md6_word_select
  import md6_pkg::*;
(
  input  logic [NW*W-1:0] i_table,
  input  logic [KW-1:0]   i_k,
  output logic [W-1:0]    o_word
);

  // Out-of-range offsets yield zero rather than X.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < NW; i++)
      if (i_k == KW'(i)) o_word = i_table[i*W +: W];
  end

endmodule

// File: rtl/md6_s_step_sequencer.sv
// Streams S constants round-major, one word per handshake.
// Ports: i_clk, i_rst, i_s_table, i_start, i_num_rounds, s_if, o_busy, o_done.
module md6_s_step_sequencer
  import md6_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NW*W-1:0]     i_s_table,
  input  logic                i_start,
  input  logic [RW-1:0]       i_num_rounds,
  md6_s_step_sequencer_if.master s_if,
  output logic                o_busy,
  output logic                o_done
);

  state_t        r_state, w_state;
  logic [RW-1:0] r_nr, w_nr;
  logic [RW-1:0] r_round, w_round;
  logic [SW-1:0] r_step, w_step;
  logic [W-1:0]  r_word, w_word;
  logic          r_valid, w_valid;
  logic          r_last, w_last;
  logic          w_load;
  logic [RW-1:0] w_nr_in;
  logic [KW-1:0] w_k;
  logic [W-1:0]  w_sel;
  logic          w_hs;

  assign w_nr_in = (i_num_rounds > RW'(R_MAX))
                 ? RW'(R_MAX) : i_num_rounds;
  assign w_hs    = r_valid & s_if.s_ready;

  always_comb begin
    w_state = r_state;
    w_nr    = r_nr;
    w_round = r_round;
    w_step  = r_step;
    w_valid = r_valid;
    w_last  = r_last;
    w_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nr    = w_nr_in;
          w_round = '0;
          w_step  = '0;
          if (w_nr_in != '0) begin
            w_state = RUN;
            w_valid = 1'b1;
            w_load  = 1'b1;
            w_last  = (w_nr_in == RW'(1)) &&
                      (SW'(0) == SW'(C-1));
          end else begin
            w_state = DONE;
          end
        end
      end
      RUN: begin
        if (w_hs) begin
          if (r_last) begin
            w_state = DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
          end else begin
            if (r_step == SW'(C-1)) begin
              w_step  = '0;
              w_round = r_round + RW'(1);
            end else begin
              w_step  = r_step + SW'(1);
            end
            w_load = 1'b1;
            w_last = (w_round == r_nr - RW'(1)) &&
                     (w_step == SW'(C-1));
          end
        end
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // Offset of the word being loaded next cycle.
  assign w_k = KW'(w_round) * KW'(C) + KW'(w_step);

  md6_word_select u_sel (
    .i_table (i_s_table),
    .i_k     (w_k),
    .o_word  (w_sel)
  );

  always_comb begin
    w_word = r_word;
    if (w_load) w_word = w_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_nr    <= '0;
      r_round <= '0;
      r_step  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_nr    <= w_nr;
      r_round <= w_round;
      r_step  <= w_step;
      r_word  <= w_word;
      r_valid <= w_valid;
      r_last  <= w_last;
    end
  end

  assign s_if.s_word    = r_word;
  assign s_if.s_valid   = r_valid;
  assign s_if.round_idx = r_round;
  assign s_if.step_idx  = r_step;
  assign s_if.last_step = r_last;
  assign o_busy         = (r_state == RUN);
  assign o_done         = (r_state == DONE);

endmodule

// File: tb/tb_md6_s_step_sequencer.sv
// Directed bench for md6_s_step_sequencer.
// Inputs driven and outputs sampled on the falling edge.
module tb_md6_s_step_sequencer;
  import md6_pkg::*;

  logic            clk;
  logic            rst;
  logic [NW*W-1:0] table_bus;
  logic            start;
  logic [RW-1:0]   num_rounds;
  logic            busy;
  logic            done;
  int              checks;
  int              errors;

  md6_s_step_sequencer_if u_if ();

  md6_s_step_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_s_table    (table_bus),
    .i_start      (start),
    .i_num_rounds (num_rounds),
    .s_if         (u_if),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ew(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {32'hC0DE0000 | kk, kk};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_word(input int k, input int n);
    chk("valid", 64'(u_if.s_valid), 64'(1));
    chk("word", u_if.s_word, ew(k));
    chk("round", 64'(u_if.round_idx), 64'(k / 16));
    chk("step", 64'(u_if.step_idx), 64'(k % 16));
    chk("last", 64'(u_if.last_step), 64'(k == n - 1));
    chk("busy", 64'(busy), 64'(1));
    chk("nodone", 64'(done), 64'(0));
  endtask

  task automatic do_start(input int nr);
    num_rounds = RW'(nr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tail();
    chk("done", 64'(done), 64'(1));
    chk("valid_end", 64'(u_if.s_valid), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done_off", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic stream(input int n, input int st_at,
                        input int rst_at);
    for (int k = 0; k < n; k++) begin
      chk_word(k, n);
      if (k == rst_at) begin
        rst = 1'b1;
        return;
      end
      start = (k == st_at);
      if (k == st_at) num_rounds = RW'(1);
      @(negedge clk);
    end
    start = 1'b0;
    tail();
  endtask

  initial begin
    int pat [4];
    int k;
    int cyc;
    checks = 0;
    errors = 0;
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < NW; i++)
      table_bus[i*W +: W] = ew(i);
    rst = 1'b1;
    start = 1'b0;
    num_rounds = '0;
    u_if.s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_word", u_if.s_word, 64'(0));
    chk("rst_valid", 64'(u_if.s_valid), 64'(0));
    chk("rst_round", 64'(u_if.round_idx), 64'(0));
    chk("rst_step", 64'(u_if.step_idx), 64'(0));
    chk("rst_last", 64'(u_if.last_step), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: two rounds back-to-back
    do_start(2);
    stream(32, -1, -1);

    // 2: saturating round count
    do_start(15);
    stream(176, -1, -1);

    // 3: zero rounds
    do_start(0);
    chk("z_done", 64'(done), 64'(1));
    chk("z_valid", 64'(u_if.s_valid), 64'(0));
    chk("z_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("z_done_off", 64'(done), 64'(0));
    chk("z_busy2", 64'(busy), 64'(0));

    // 4: ready pattern 1,0,0,1
    do_start(1);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      chk_word(k, 16);
      u_if.s_ready = pat[cyc % 4] != 0;
      if (u_if.s_ready) k++;
      cyc++;
      @(negedge clk);
    end
    chk("t4_count", 64'(k), 64'(16));
    u_if.s_ready = 1'b1;
    tail();

    // 5: restart attempt mid-run
    do_start(2);
    stream(32, 5, -1);

    // 6: reset mid-sequence
    do_start(3);
    stream(48, -1, 20);
    @(negedge clk);
    chk("r_word", u_if.s_word, 64'(0));
    chk("r_valid", 64'(u_if.s_valid), 64'(0));
    chk("r_round", 64'(u_if.round_idx), 64'(0));
    chk("r_step", 64'(u_if.step_idx), 64'(0));
    chk("r_last", 64'(u_if.last_step), 64'(0));
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_done", 64'(done), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("r_done2", 64'(done), 64'(0));
    chk("r_valid2", 64'(u_if.s_valid), 64'(0));
    do_start(1);
    stream(16, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
